// File: rtl/rs_stream_pkg.sv
// Shared types, constants and helpers for the RS streaming datapath.
// Frame geometry is derived here so serializer and deserializer agree on frame size.
// Pure declarations; no logic.
package rs_stream_pkg;

  localparam int RS_N  = 200;
  localparam int RS_K  = 168;
  localparam int RS_SW = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } p2s_state_t;

  // Codewords carry all N symbols; decoded frames carry only the K information symbols.
  function automatic int frame_bits(input string mode, input int n, input int k, input int sw);
    return (mode == "ENCODE") ? n * sw : k * sw;
  endfunction

endpackage

// File: rtl/parallel_to_serial_if.sv
// Parallel frame input and serial bit output handshakes of the serializer.
// The master side is upstream/downstream logic; the slave side is the serializer.
// Wires only; no latency.
interface parallel_to_serial_if
  import rs_stream_pkg::*;
#(
  parameter int DATA_W = RS_N * RS_SW
);

  logic [DATA_W-1:0] parallel_data_in;
  logic              parallel_data_valid;
  logic              parallel_data_ready;
  logic              serial_data_out;
  logic              serial_data_valid;
  logic              serial_data_ready;

  modport master (
    output parallel_data_in,
    output parallel_data_valid,
    input  parallel_data_ready,
    input  serial_data_out,
    input  serial_data_valid,
    output serial_data_ready
  );

  modport slave (
    input  parallel_data_in,
    input  parallel_data_valid,
    output parallel_data_ready,
    output serial_data_out,
    output serial_data_valid,
    input  serial_data_ready
  );

endinterface

// File: rtl/rs_frame_fifo.sv
// Synchronous frame FIFO with occupancy count; head word is presented combinationally.
// Latency: a pushed frame is visible at the head one cycle after the push edge.
// Backpressure: in_ready drops when count == DEPTH; pop is ignored when empty.
module rs_frame_fifo #(
  parameter int  WIDTH = 1344,
  parameter int  DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_ready && out_valid;

  // Frame storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/parallel_to_serial.sv
// Buffers parallel RS frames and serializes each one LSB first onto a valid/ready bit stream.
// Latency: first bit valid one cycle after the frame is accepted when idle; back-to-back frames have no bubble.
// Backpressure: bit held while serial_data_ready=0; parallel_data_ready drops when the frame FIFO is full.
module parallel_to_serial
  import rs_stream_pkg::*;
#(
  parameter int    N            = RS_N,
  parameter int    K            = RS_K,
  parameter int    SYMBOL_WIDTH = RS_SW,
  parameter string MODE         = "DECODE",
  parameter int    FIFO_DEPTH   = 2
) (
  input  logic                clk,
  input  logic                rstn,
  parallel_to_serial_if.slave bus,
  output logic                serializing,
  output logic [15:0]         bits_sent,
  output logic                buffer_full,
  output logic [3:0]          frames_buffered,
  output logic [31:0]         frames_sent,
  output logic [31:0]         starved_cycles
);

  localparam int DATA_W     = N * SYMBOL_WIDTH;
  localparam int FRAME_BITS = frame_bits(MODE, N, K, SYMBOL_WIDTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int BIT_W      = $clog2(FRAME_BITS + 1);

  localparam logic [0:0]       ST_IDLE  = IDLE;
  localparam logic [0:0]       ST_SHIFT = SHIFT;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

  logic [0:0]            state;
  logic [FRAME_BITS-1:0] shift_q;
  logic [BIT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] fifo_head;
  logic                  fifo_vld;
  logic                  fifo_pop;
  logic                  fifo_in_rdy;
  logic [CNT_W-1:0]      fifo_count;
  logic                  last_xfer;

  // In DECODE mode the parity symbols above FRAME_BITS are carried on the bus but not serialized.
  generate
    if (DATA_W > FRAME_BITS) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^bus.parallel_data_in[DATA_W-1:FRAME_BITS];
    end
  endgenerate

  rs_frame_fifo #(
    .WIDTH (FRAME_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .in_data   (bus.parallel_data_in[FRAME_BITS-1:0]),
    .in_valid  (bus.parallel_data_valid),
    .in_ready  (fifo_in_rdy),
    .out_data  (fifo_head),
    .out_valid (fifo_vld),
    .out_ready (fifo_pop),
    .count     (fifo_count)
  );

  // Pop either to start from idle or to chain the next frame onto the final bit transfer.
  assign last_xfer = (state == ST_SHIFT) && bus.serial_data_ready && (bit_cnt == LAST_BIT);
  assign fifo_pop  = fifo_vld && ((state == ST_IDLE) || last_xfer);

  assign serializing             = (state == ST_SHIFT);
  assign bus.serial_data_valid   = serializing;
  assign bus.serial_data_out     = shift_q[0];
  assign bus.parallel_data_ready = fifo_in_rdy;
  assign buffer_full             = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign frames_buffered         = 4'(fifo_count);
  assign bits_sent               = 16'(bit_cnt);

  // Serializer FSM: load from FIFO head, shift one bit per accepted transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      shift_q <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_vld) begin
            shift_q <= fifo_head;
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end
        end
        default: begin
          if (bus.serial_data_ready) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (fifo_vld) begin
                shift_q <= fifo_head;
              end else begin
                shift_q <= shift_q >> 1;
                state   <= ST_IDLE;
              end
            end else begin
              shift_q <= shift_q >> 1;
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
      endcase
    end
  end

  // Status counters: completed frames, and idle cycles where downstream was waiting on us.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frames_sent    <= '0;
      starved_cycles <= '0;
    end else begin
      if (last_xfer) frames_sent <= frames_sent + 32'd1;
      if (bus.serial_data_ready && !bus.serial_data_valid && (frames_sent != '0))
        starved_cycles <= starved_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Scoreboard bench for parallel_to_serial in DECODE and ENCODE configurations.
module tb_parallel_to_serial;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  parallel_to_serial_if if_dec ();
  parallel_to_serial_if if_enc ();

  logic        dec_ser, enc_ser, dec_full, enc_full;
  logic [15:0] dec_bits, enc_bits;
  logic [3:0]  dec_fb, enc_fb;
  logic [31:0] dec_fs, enc_fs, dec_starved, enc_starved;

  parallel_to_serial #(.MODE("DECODE")) dut_dec (
    .clk(clk), .rstn(rstn), .bus(if_dec),
    .serializing(dec_ser), .bits_sent(dec_bits), .buffer_full(dec_full),
    .frames_buffered(dec_fb), .frames_sent(dec_fs), .starved_cycles(dec_starved)
  );

  parallel_to_serial #(.MODE("ENCODE")) dut_enc (
    .clk(clk), .rstn(rstn), .bus(if_enc),
    .serializing(enc_ser), .bits_sent(enc_bits), .buffer_full(enc_full),
    .frames_buffered(enc_fb), .frames_sent(enc_fs), .starved_cycles(enc_starved)
  );

  int checks = 0;
  int errors = 0;
  bit exp_dec[$];
  bit exp_enc[$];

  logic dec_rdy  = 1'b1;
  logic rand_rdy = 1'b0;
  logic rnd_bit  = 1'b1;
  assign if_dec.serial_data_ready = rand_rdy ? rnd_bit : dec_rdy;

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decode-side monitor: bit order against scoreboard, and bit stability while stalled.
  bit hold_d   = 1'b0;
  bit hold_bit = 1'b0;
  always @(negedge clk) begin
    if (!rstn) begin
      hold_d = 1'b0;
    end else begin
      if (hold_d && if_dec.serial_data_valid)
        check("dec_hold", if_dec.serial_data_out, hold_bit);
      if (if_dec.serial_data_valid && if_dec.serial_data_ready) begin
        if (exp_dec.size() == 0) begin
          checks++; errors++;
          $display("FAIL dec_extra_bit: got a bit %0b expected none at %0t", if_dec.serial_data_out, $time);
        end else begin
          check("dec_bit", if_dec.serial_data_out, exp_dec.pop_front());
        end
      end
      hold_d   = if_dec.serial_data_valid && !if_dec.serial_data_ready;
      hold_bit = if_dec.serial_data_out;
    end
  end

  // Encode-side monitor: bit order plus length of the contiguous valid run.
  int enc_run = 0;
  int enc_last_run = 0;
  always @(negedge clk) begin
    if (rstn) begin
      if (if_enc.serial_data_valid) enc_run++;
      else if (enc_run != 0) begin
        enc_last_run = enc_run;
        enc_run = 0;
      end
      if (if_enc.serial_data_valid && if_enc.serial_data_ready) begin
        if (exp_enc.size() == 0) begin
          checks++; errors++;
          $display("FAIL enc_extra_bit: got a bit %0b expected none at %0t", if_enc.serial_data_out, $time);
        end else begin
          check("enc_bit", if_enc.serial_data_out, exp_enc.pop_front());
        end
      end
    end
  end

  task automatic push(input bit enc, input logic [1599:0] f);
    int fb = enc ? 1600 : 1344;
    int n = 0;
    bit ok = 1'b1;
    if (enc) begin
      if_enc.parallel_data_in = f; if_enc.parallel_data_valid = 1'b1;
    end else begin
      if_dec.parallel_data_in = f; if_dec.parallel_data_valid = 1'b1;
    end
    forever begin
      @(negedge clk);
      if (enc ? if_enc.parallel_data_ready : if_dec.parallel_data_ready) break;
      n++;
      if (n > 5000) begin
        checks++; errors++;
        $display("FAIL push_timeout: got no ready expected ready within 5000 cycles");
        ok = 1'b0;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      for (int b = 0; b < fb; b++) begin
        if (enc) exp_enc.push_back(f[b]);
        else     exp_dec.push_back(f[b]);
      end
    end
    #1;
    if (enc) if_enc.parallel_data_valid = 1'b0;
    else     if_dec.parallel_data_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit enc, input string name);
    for (int n = 0; n < 20000; n++) begin
      @(posedge clk); #1;
      if (enc) begin
        if (exp_enc.size() == 0 && !enc_ser && enc_fb == 0) return;
      end else begin
        if (exp_dec.size() == 0 && !dec_ser && dec_fb == 0) return;
      end
    end
    checks++; errors++;
    $display("FAIL %s: got no drain expected idle within 20000 cycles", name);
  endtask

  task automatic rand_frame(output logic [1599:0] f);
    for (int w = 0; w < 50; w++) f[w*32 +: 32] = $urandom();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1599:0] f;
    logic [31:0]   s0;
    logic [31:0]   fs0;

    rstn = 1'b0;
    if_dec.parallel_data_in = '0; if_dec.parallel_data_valid = 1'b0;
    if_enc.parallel_data_in = '0; if_enc.parallel_data_valid = 1'b0;
    if_enc.serial_data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", if_dec.serial_data_valid, 0);
    check("rst_out", if_dec.serial_data_out, 0);
    check("rst_pready", if_dec.parallel_data_ready, 1);
    check("rst_ser", dec_ser, 0);
    check("rst_bits", dec_bits, 0);
    check("rst_full", dec_full, 0);
    check("rst_fb", dec_fb, 0);
    check("rst_fs", dec_fs, 0);
    check("rst_starved", dec_starved, 0);
    check("rst_enc_pready", if_enc.parallel_data_ready, 1);
    rstn = 1'b1;

    // Single DEADBEEF frame: one-cycle load latency, LSB first, then zeros.
    f = '0;
    f[31:0] = 32'hDEADBEEF;
    push(1'b0, f);
    check("lat_fb_after_accept", dec_fb, 1);
    check("lat_not_valid_yet", if_dec.serial_data_valid, 0);
    @(posedge clk); #1;
    check("lat_valid", if_dec.serial_data_valid, 1);
    check("lat_bits0", dec_bits, 0);
    check("lat_first_bit", if_dec.serial_data_out, 1);
    check("lat_fb_popped", dec_fb, 0);
    wait_idle(1'b0, "deadbeef_drain");
    check("deadbeef_fs", dec_fs, 1);
    check("deadbeef_idle", dec_ser, 0);

    // Ready toggling 1/0: 1344 transfers complete on cycle 2687 of 2688.
    dec_rdy = 1'b0;
    f = '1;
    for (int w = 0; w < 42; w++) f[w*32 +: 32] = 32'hA5C30F1E;
    push(1'b0, f);
    @(posedge clk); #1;
    check("tog_loaded", dec_ser, 1);
    fs0 = dec_fs;
    for (int i = 1; i <= 2688; i++) begin
      dec_rdy = (i % 2) == 1;
      @(posedge clk); #1;
      if (i == 2686) begin
        check("tog_bits_2686", dec_bits, 1343);
        check("tog_fs_2686", dec_fs, fs0);
      end
    end
    check("tog_fs_done", dec_fs, fs0 + 1);
    check("tog_idle", dec_ser, 0);
    dec_rdy = 1'b1;

    // Starvation: ten idle cycles with ready high after frames have been sent.
    s0 = dec_starved;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("starve_pready", if_dec.parallel_data_ready, 1);
    end
    check("starve_delta", dec_starved - s0, 10);

    // Reset after 500 bits with one frame queued.
    rand_frame(f);
    push(1'b0, f);
    rand_frame(f);
    push(1'b0, f);
    for (int n = 0; n < 2000 && dec_bits != 16'd500; n++) begin
      @(posedge clk); #1;
    end
    check("mid_bits", dec_bits, 500);
    check("mid_fb", dec_fb, 1);
    rstn = 1'b0;
    #1;
    exp_dec.delete();
    check("mid_rst_valid", if_dec.serial_data_valid, 0);
    check("mid_rst_out", if_dec.serial_data_out, 0);
    check("mid_rst_pready", if_dec.parallel_data_ready, 1);
    check("mid_rst_bits", dec_bits, 0);
    check("mid_rst_fb", dec_fb, 0);
    check("mid_rst_fs", dec_fs, 0);
    check("mid_rst_starved", dec_starved, 0);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    rand_frame(f);
    push(1'b0, f);
    @(posedge clk); #1;
    check("post_rst_bits", dec_bits, 0);
    wait_idle(1'b0, "post_rst_drain");
    check("post_rst_fs", dec_fs, 1);

    // Random frames under random downstream backpressure.
    fs0 = dec_fs;
    rand_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_frame(f);
      push(1'b0, f);
    end
    wait_idle(1'b0, "rand_drain");
    rand_rdy = 1'b0;
    check("rand_fs", dec_fs, fs0 + 5);

    // ENCODE: three back-to-back codewords, FIFO fills, stream has no bubble.
    for (int i = 0; i < 3; i++) begin
      rand_frame(f);
      push(1'b1, f);
    end
    check("enc_full", enc_full, 1);
    check("enc_fb", enc_fb, 2);
    check("enc_pready_low", if_enc.parallel_data_ready, 0);
    wait_idle(1'b1, "enc_drain");
    @(negedge clk); #1;
    check("enc_fs", enc_fs, 3);
    check("enc_run", enc_last_run, 4800);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
